// File: rtl/fd_corner_collector.sv
// fd_corner_collector: scores FAST9 corners and queues (address, pixel, score)
// records in a show-ahead FIFO that drains over a valid/ready interface.
// Pipeline: excess terms at edge N, score sum at N+1, FIFO push at N+2.
module fd_corner_collector #(
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4,
    parameter int SCORE_W = 12,
    parameter int DROP_W  = 16
) (
    input  logic               clock,
    input  logic               nReset,
    input  logic               clear,
    input  logic               isCorner,
    input  logic [14:0]        refAddr,
    input  logic [7:0]         refPixel,
    input  logic [127:0]       adjPixel,
    input  logic [7:0]         thres,
    output logic               outValid,
    input  logic               outReady,
    output logic [14:0]        outAddr,
    output logic [7:0]         outPixel,
    output logic [SCORE_W-1:0] outScore,
    output logic [PTR_W:0]     fifoCount,
    output logic               overflow,
    output logic [DROP_W-1:0]  dropCount
);

    localparam int REC_W = 15 + 8 + SCORE_W;
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX   = '1;

    // ---------------- stage 1: per-neighbour excess over threshold ----------
    logic [7:0]  excessComb [16];
    logic        s1Valid;
    logic [14:0] s1Addr;
    logic [7:0]  s1Pixel;
    logic [7:0]  s1Excess [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : gExcess
            logic [8:0] diff;
            logic [7:0] absDiff;
            // 9-bit difference so the sign bit is available for the magnitude
            assign diff       = {1'b0, adjPixel[8*gi +: 8]} - {1'b0, refPixel};
            assign absDiff    = diff[8] ? (~diff[7:0] + 8'd1) : diff[7:0];
            assign excessComb[gi] = (absDiff > thres) ? (absDiff - thres) : 8'd0;
        end
    endgenerate

    // Stage-1 register: pixel address is one behind the detector address
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            s1Valid <= 1'b0;
            s1Addr  <= '0;
            s1Pixel <= '0;
            for (int i = 0; i < 16; i++) s1Excess[i] <= '0;
        end else begin
            s1Valid <= isCorner & ~clear;
            s1Addr  <= refAddr - 15'd1;
            s1Pixel <= refPixel;
            for (int i = 0; i < 16; i++) s1Excess[i] <= excessComb[i];
        end
    end

    // ---------------- stage 2: score = sum of excess terms ------------------
    logic [SCORE_W-1:0] scoreSum;
    logic               s2Valid;
    logic [REC_W-1:0]   s2Rec;

    // Adder tree over the sixteen excess terms; 16*255 fits in SCORE_W bits
    always_comb begin
        scoreSum = '0;
        for (int i = 0; i < 16; i++) scoreSum = scoreSum + SCORE_W'(s1Excess[i]);
    end

    // Stage-2 register holds a complete record ready for the FIFO
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            s2Valid <= 1'b0;
            s2Rec   <= '0;
        end else begin
            s2Valid <= s1Valid & ~clear;
            s2Rec   <= {s1Addr, s1Pixel, scoreSum};
        end
    end

    // ---------------- show-ahead FIFO ---------------------------------------
    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr, wrPtrNext, rdPtrNext;
    logic [PTR_W:0]   countNext;
    logic [REC_W-1:0] headReg, headNext;
    logic             full, doPush, doPop, doDrop, emptyAfterPop;
    logic             overflowNext;
    logic [DROP_W-1:0] dropNext;

    // Push/pop arbitration; a pop on a full FIFO frees the slot for the push
    always_comb begin
        full          = (fifoCount == FULL_COUNT);
        doPop         = outValid & outReady & ~clear;
        doPush        = s2Valid & ~clear & (~full | doPop);
        doDrop        = s2Valid & ~clear & full & ~doPop;
        emptyAfterPop = (fifoCount == '0) || ((fifoCount == (PTR_W + 1)'(1)) && doPop);
        wrPtrNext     = wrPtr + PTR_W'(doPush);
        rdPtrNext     = rdPtr + PTR_W'(doPop);
        countNext     = fifoCount + (PTR_W + 1)'(doPush) - (PTR_W + 1)'(doPop);
        overflowNext  = overflow | doDrop;
        dropNext      = (doDrop && dropCount != DROP_MAX) ? dropCount + 1'b1 : dropCount;
        if (clear) begin
            wrPtrNext    = '0;
            rdPtrNext    = '0;
            countNext    = '0;
            overflowNext = 1'b0;
            dropNext     = '0;
        end
        // Next head: hold when empty, bypass the incoming record when it lands
        // in an otherwise empty FIFO, else read the entry at the new read pointer
        headNext = headReg;
        if (countNext != '0) begin
            if (doPush && emptyAfterPop) headNext = s2Rec;
            else                         headNext = mem[rdPtrNext];
        end
    end

    // Record storage; no reset so it maps onto plain RAM
    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= s2Rec;
    end

    // FIFO control, head register and drop statistics
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            outValid  <= 1'b0;
            headReg   <= '0;
            overflow  <= 1'b0;
            dropCount <= '0;
        end else begin
            wrPtr     <= wrPtrNext;
            rdPtr     <= rdPtrNext;
            fifoCount <= countNext;
            outValid  <= (countNext != '0);
            headReg   <= headNext;
            overflow  <= overflowNext;
            dropCount <= dropNext;
        end
    end

    assign outAddr  = headReg[REC_W-1 -: 15];
    assign outPixel = headReg[SCORE_W +: 8];
    assign outScore = headReg[SCORE_W-1:0];

endmodule

// File: tb/tb_fd_corner_collector.sv
// tb_fd_corner_collector: queue-based scoreboard for the corner collector.
// Expected records are computed when a corner is driven, walk a two-stage
// model pipeline, and are compared against the DUT head every cycle.
module tb_fd_corner_collector;

    logic         clock = 1'b0;
    logic         nReset = 1'b0;
    logic         clear = 1'b0;
    logic         isCorner = 1'b0;
    logic [14:0]  refAddr = '0;
    logic [7:0]   refPixel = '0;
    logic [127:0] adjPixel = '0;
    logic [7:0]   thres = '0;
    logic         outReady = 1'b0;
    logic         outValid;
    logic [14:0]  outAddr;
    logic [7:0]   outPixel;
    logic [11:0]  outScore;
    logic [4:0]   fifoCount;
    logic         overflow;
    logic [15:0]  dropCount;

    fd_corner_collector dut (
        .clock(clock), .nReset(nReset), .clear(clear), .isCorner(isCorner),
        .refAddr(refAddr), .refPixel(refPixel), .adjPixel(adjPixel), .thres(thres),
        .outValid(outValid), .outReady(outReady), .outAddr(outAddr),
        .outPixel(outPixel), .outScore(outScore), .fifoCount(fifoCount),
        .overflow(overflow), .dropCount(dropCount)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  pix;
        logic [11:0] score;
    } recT;

    recT  q[$];
    recT  p1, p2, shown;
    bit   p1v, p2v, mOvf;
    int   mDrop, popCount, maxCount;
    int   nChecks = 0;
    int   nFails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic recT makeRec(input logic [14:0] a, input logic [7:0] r,
                                    input logic [127:0] adj, input logic [7:0] t);
        recT rec;
        int  s, d;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            d = int'(adj[8*i +: 8]) - int'(r);
            if (d < 0) d = -d;
            if (d > int'(t)) s += d - int'(t);
        end
        rec.addr  = a - 15'd1;
        rec.pix   = r;
        rec.score = 12'(s);
        return rec;
    endfunction

    task automatic modelReset();
        q.delete();
        p1v = 0; p2v = 0; mOvf = 0; mDrop = 0;
        p1 = '0; p2 = '0; shown = '0;
    endtask

    // Reference behaviour for one rising edge, using the inputs held across it
    task automatic modelStep();
        recT r;
        if (clear) begin
            q.delete();
            p1v = 0; p2v = 0; mOvf = 0; mDrop = 0;
        end else begin
            if (q.size() > 0 && outReady) begin
                r = q.pop_front();
                popCount++;
                $display("pop addr=%0d pixel=0x%02h score=%0d", r.addr, r.pix, r.score);
            end
            if (p2v) begin
                if (q.size() < 16) q.push_back(p2);
                else begin
                    mOvf = 1;
                    if (mDrop < 65535) mDrop++;
                end
            end
            p2 = p1; p2v = p1v;
            p1v = isCorner;
            if (isCorner) p1 = makeRec(refAddr, refPixel, adjPixel, thres);
        end
        if (q.size() > 0) shown = q[0];
    endtask

    task automatic compareAll();
        recT e;
        e = (q.size() > 0) ? q[0] : shown;
        check("outValid", outValid, q.size() != 0);
        check("fifoCount", fifoCount, q.size());
        check("overflow", overflow, mOvf);
        check("dropCount", dropCount, mDrop);
        check("outAddr", outAddr, e.addr);
        check("outPixel", outPixel, e.pix);
        check("outScore", outScore, e.score);
        if (int'(fifoCount) > maxCount) maxCount = int'(fifoCount);
    endtask

    task automatic cycle();
        @(posedge clock);
        modelStep();
        @(negedge clock);
        compareAll();
    endtask

    task automatic setCorner(input logic [14:0] a, input logic [7:0] r,
                             input logic [127:0] adj, input logic [7:0] t);
        isCorner = 1'b1; refAddr = a; refPixel = r; adjPixel = adj; thres = t;
    endtask

    task automatic setIdle();
        isCorner = 1'b0;
    endtask

    task automatic randomCorner(input logic [14:0] a);
        setCorner(a, 8'($urandom_range(0, 255)),
                  {$urandom, $urandom, $urandom, $urandom}, 8'($urandom_range(0, 60)));
    endtask

    task automatic asyncReset();
        @(negedge clock);
        #2;
        nReset = 1'b0;
        #1;
        check("rst outValid", outValid, 0);
        check("rst fifoCount", fifoCount, 0);
        check("rst overflow", overflow, 0);
        check("rst dropCount", dropCount, 0);
        check("rst outAddr", outAddr, 0);
        check("rst outScore", outScore, 0);
        modelReset();
        setIdle();
        clear = 1'b0;
        outReady = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        nReset = 1'b1;
        compareAll();
    endtask

    initial begin
        modelReset();
        popCount = 0;
        maxCount = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        nReset = 1'b1;
        check("init outValid", outValid, 0);
        check("init fifoCount", fifoCount, 0);
        check("init outPixel", outPixel, 0);
        check("init dropCount", dropCount, 0);

        // Single corner: uniform excess of 0x10 on all sixteen neighbours
        setCorner(15'd101, 8'h80, {16{8'hA0}}, 8'h10);
        cycle();
        check("t1 latency edge N", outValid, 0);
        setIdle();
        cycle();
        check("t1 latency edge N+1", outValid, 0);
        cycle();
        check("t1 outValid", outValid, 1);
        check("t1 outAddr", outAddr, 100);
        check("t1 outPixel", outPixel, 8'h80);
        check("t1 outScore", outScore, 256);
        outReady = 1'b1;
        cycle();
        outReady = 1'b0;

        // Alternating 0x00/0xFF: only the 0x00 neighbours exceed 0x7F, by one
        setCorner(15'd500, 8'h80, {8{16'hFF00}}, 8'h7F);
        cycle();
        setIdle();
        repeat (2) cycle();
        check("t2 outScore", outScore, 8);
        outReady = 1'b1;
        cycle();
        outReady = 1'b0;

        // Fill with the consumer stalled: 16 kept, 4 dropped
        for (int k = 0; k < 20; k++) begin
            randomCorner(15'(200 + k));
            cycle();
        end
        setIdle();
        repeat (3) cycle();
        check("t3 fifoCount", fifoCount, 16);
        check("t3 dropCount", dropCount, 4);
        check("t3 overflow", overflow, 1);

        // Full FIFO: push and pop on the same edge, nothing dropped
        randomCorner(15'd300);
        cycle();
        setIdle();
        cycle();
        outReady = 1'b1;
        cycle();
        outReady = 1'b0;
        check("t4 fifoCount", fifoCount, 16);
        check("t4 dropCount", dropCount, 4);
        cycle();

        // Drain and flush, then stream 40 corners with a ready consumer
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check("clear overflow", overflow, 0);
        check("clear dropCount", dropCount, 0);
        outReady = 1'b1;
        popCount = 0;
        maxCount = 0;
        for (int k = 0; k < 40; k++) begin
            randomCorner(15'(k));
            cycle();
        end
        setIdle();
        repeat (4) cycle();
        check("t5 popCount", popCount, 40);
        check("t5 maxCount<=2", maxCount <= 2, 1);
        outReady = 1'b0;

        // Clear with five queued and two in flight
        for (int k = 0; k < 7; k++) begin
            randomCorner(15'(1000 + k));
            cycle();
        end
        setIdle();
        check("t6 queued", fifoCount, 5);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check("t6 clear fifoCount", fifoCount, 0);
        check("t6 clear outValid", outValid, 0);
        repeat (4) cycle();
        check("t6 clear no stale", fifoCount, 0);

        // Same scenario, flushed by asynchronous reset instead
        for (int k = 0; k < 7; k++) begin
            randomCorner(15'(2000 + k));
            cycle();
        end
        setIdle();
        check("t6 queued again", fifoCount, 5);
        asyncReset();
        repeat (4) cycle();
        check("t6 reset no stale", outValid, 0);
        check("t6 reset fifoCount", fifoCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
